// File: rtl/spi_master.sv
// SPI mode-0 master: one byte per request, optional slave-select hold between
// bytes, programmable sclk half-period and minimum inter-frame ss gap.
module spi_master #(
    parameter int CLK_DIV = 2,
    parameter int GAP     = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] io_tx_data,
    input  logic       io_tx_last,
    input  logic       io_tx_valid,
    output logic       io_tx_ready,
    output logic [7:0] io_rx_data,
    output logic       io_rx_valid,
    output logic       io_busy,
    output logic       io_ss,
    output logic       io_sclk,
    output logic       io_mosi,
    input  logic       io_miso
);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_SHIFT     = 3'd1;
    localparam logic [2:0] ST_WAIT_NEXT = 3'd2;
    localparam logic [2:0] ST_TAIL      = 3'd3;
    localparam logic [2:0] ST_GAP       = 3'd4;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_LAST = 8'(GAP - 1);
    localparam int         SAMP_DLY = (CLK_DIV >= 2) ? 2 : 1;

    logic [2:0] r_state;
    logic [7:0] r_cnt;
    logic [3:0] r_tog;
    logic [7:0] r_tx_sh;
    logic       r_last;
    logic [7:0] r_rx_sh;
    logic [7:0] r_rx_data;
    logic       r_rx_valid;
    logic       r_ready;
    logic       r_ss;
    logic       r_sclk;
    logic       r_mosi;
    logic       r_miso_s1;
    logic       r_miso_s2;
    logic [1:0] r_samp_pend;

    logic       w_accept;
    logic       w_div_done;
    logic       w_rise;
    logic       w_samp;
    logic [7:0] w_rx_next;

    assign w_accept   = io_tx_valid & r_ready;
    assign w_div_done = (r_cnt == DIV_LAST);
    assign w_rise     = (r_state == ST_SHIFT) && w_div_done && !r_sclk;
    assign w_samp     = r_samp_pend[SAMP_DLY-1];
    assign w_rx_next  = {r_rx_sh[6:0], r_miso_s2};

    // NOTE: state lives in flops updated with non-blocking assignments only, so
    // every block sees the pre-edge values regardless of evaluation order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_miso_s1 <= 1'b0;
            r_miso_s2 <= 1'b0;
        end else begin
            r_miso_s1 <= io_miso;
            r_miso_s2 <= r_miso_s1;
        end
    end

    // Sampling two clk after the rising toggle makes the shifted-in bit equal
    // to the pin value at that toggle, undoing the synchroniser latency.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_samp_pend <= 2'b00;
            r_rx_sh     <= 8'h00;
        end else begin
            r_samp_pend <= {r_samp_pend[0], w_rise};
            if (w_samp) begin
                r_rx_sh <= w_rx_next;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 8'h00;
            r_tog      <= 4'h0;
            r_tx_sh    <= 8'h00;
            r_last     <= 1'b0;
            r_rx_data  <= 8'h00;
            r_rx_valid <= 1'b0;
            r_ready    <= 1'b0;
            r_ss       <= 1'b1;
            r_sclk     <= 1'b0;
            r_mosi     <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            case (r_state)
                ST_IDLE, ST_WAIT_NEXT: begin
                    if (w_accept) begin
                        r_state <= ST_SHIFT;
                        r_tx_sh <= io_tx_data;
                        r_last  <= io_tx_last;
                        r_mosi  <= io_tx_data[7];
                        r_ss    <= 1'b0;
                        r_cnt   <= 8'h00;
                        r_tog   <= 4'h0;
                        r_ready <= 1'b0;
                    end else begin
                        r_ready <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (w_div_done) begin
                        r_cnt  <= 8'h00;
                        r_sclk <= ~r_sclk;
                        r_tog  <= r_tog + 4'd1;
                        if (r_sclk) begin
                            if (r_tog == 4'd15) begin
                                r_rx_valid <= 1'b1;
                                r_rx_data  <= w_samp ? w_rx_next : r_rx_sh;
                                if (r_last) begin
                                    r_state <= ST_TAIL;
                                end else begin
                                    r_state <= ST_WAIT_NEXT;
                                    r_ready <= 1'b1;
                                end
                            end else begin
                                r_mosi  <= r_tx_sh[6];
                                r_tx_sh <= {r_tx_sh[6:0], 1'b0};
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                ST_TAIL: begin
                    if (w_div_done) begin
                        r_cnt   <= 8'h00;
                        r_ss    <= 1'b1;
                        r_state <= ST_GAP;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                ST_GAP: begin
                    if (r_cnt == GAP_LAST) begin
                        r_cnt   <= 8'h00;
                        r_state <= ST_IDLE;
                        r_ready <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign io_tx_ready = r_ready;
    assign io_rx_data  = r_rx_data;
    assign io_rx_valid = r_rx_valid;
    assign io_busy     = (r_state != ST_IDLE);
    assign io_ss       = r_ss;
    assign io_sclk     = r_sclk;
    assign io_mosi     = r_mosi;

endmodule
